pool2d_window_buffer: RTL and testbench

//  Streaming sliding-window generator; sits directly upstream of max_pool2d.

---
 rtl/pool2d_window_buffer_if.sv | 24 ++
 rtl/pool2d_window_buffer.sv | 120 ++++++++++++
 tb/tb_pool2d_window_buffer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2d_window_buffer_if.sv
// Stream bundle for the pooling window buffer: element in, flat KHxKW window out.
// Latency: n/a (wiring only).  Backpressure: valid/ready on both sides.
interface pool2d_window_buffer_if #(
    parameter int P0 = 8,
    parameter int KH = 2,
    parameter int KW = 2
);
    logic [P0-1:0] data_in_0;
    logic          data_in_0_valid;
    logic          data_in_0_ready;
    logic [P0-1:0] data_out_0 [KH*KW];
    logic          data_out_0_valid;
    logic          data_out_0_ready;

    modport master (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport slave (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/pool2d_window_buffer.sv
// Sliding-window generator: row-major elements in, one flat KHxKW window per strided output position.
// Latency: window valid 1 cycle after the handshake of its bottom-right element.
// Backpressure: input stalls while a window is held unaccepted; window stays stable.
module pool2d_window_buffer #(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 3,
    parameter int DATA_IN_0_WIDTH       = 4,
    parameter int DATA_IN_0_HEIGHT      = 4,
    parameter int KERNEL_WIDTH          = 2,
    parameter int KERNEL_HEIGHT         = 2,
    parameter int STRIDE                = 2
) (
    input logic                    clk,
    input logic                    rst,
    pool2d_window_buffer_if.master io
);
    localparam int P0   = DATA_IN_0_PRECISION_0;
    localparam int W    = DATA_IN_0_WIDTH;
    localparam int H    = DATA_IN_0_HEIGHT;
    localparam int KW   = KERNEL_WIDTH;
    localparam int KH   = KERNEL_HEIGHT;
    localparam int NWIN = KH * KW;
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
    localparam int RW   = (H > 1) ? $clog2(H) : 1;
    localparam int SW   = (KH > 1) ? $clog2(KH) : 1;

    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_frac
        $error("fractional bits exceed element width");
    end
    if (W < KW || H < KH || KW < 1 || KH < 1 || STRIDE < 1) begin : g_bad_geom
        $error("illegal kernel/map geometry");
    end

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          out_vld_q, out_vld_d;
    logic [P0-1:0] win_q [NWIN];
    logic [P0-1:0] win_d [NWIN];
    logic [P0-1:0] line_q [KH][W];
    logic [SW-1:0] src_slot [KH];
    logic [CW-1:0] src_col [KW];
    logic          in_hs, last_col, last_row, trig;

    assign io.data_in_0_ready  = !out_vld_q || io.data_out_0_ready;
    assign io.data_out_0_valid = out_vld_q;
    assign io.data_out_0       = win_q;

    assign in_hs    = io.data_in_0_valid && io.data_in_0_ready;
    assign last_col = (col_cnt_q == CW'(W - 1));
    assign last_row = (row_cnt_q == RW'(H - 1));
    assign trig     = in_hs
                   && (int'(row_cnt_q) >= KH - 1) && (int'(col_cnt_q) >= KW - 1)
                   && (((int'(row_cnt_q) - (KH - 1)) % STRIDE) == 0)
                   && (((int'(col_cnt_q) - (KW - 1)) % STRIDE) == 0);

    // Window row m lives in slot (slot_q - (KH-1) + m) mod KH, i.e. (slot_q + m + 1) mod KH.
    always_comb begin
        for (int m = 0; m < KH; m++) begin
            if (int'(slot_q) + m + 1 >= KH) src_slot[m] = SW'(int'(slot_q) + m + 1 - KH);
            else                            src_slot[m] = SW'(int'(slot_q) + m + 1);
        end
        for (int n = 0; n < KW; n++) begin
            src_col[n] = CW'(int'(col_cnt_q) - (KW - 1) + n);
        end
    end

    always_comb begin
        for (int m = 0; m < KH; m++) begin
            for (int n = 0; n < KW; n++) begin
                win_d[m*KW+n] = line_q[src_slot[m]][src_col[n]];
            end
        end
        win_d[NWIN-1] = io.data_in_0;
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        slot_d    = slot_q;
        if (in_hs) begin
            if (last_col) begin
                col_cnt_d = '0;
                if (last_row) begin
                    row_cnt_d = '0;
                    slot_d    = '0;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    slot_d    = (slot_q == SW'(KH - 1)) ? '0 : slot_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
        if (trig)                       out_vld_d = 1'b1;
        else if (io.data_out_0_ready)   out_vld_d = 1'b0;
        else                            out_vld_d = out_vld_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            slot_q    <= '0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < NWIN; i++) win_q[i] <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            slot_q    <= slot_d;
            out_vld_q <= out_vld_d;
            if (trig) win_q <= win_d;
        end
    end

    // Line storage carries no reset; stale contents are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (in_hs) line_q[slot_q][col_cnt_q] <= io.data_in_0;
    end
endmodule

// File: tb/tb_pool2d_window_buffer.sv
// Scoreboard bench: three parameterisations of the window buffer driven with directed frames;
// a negedge monitor pops expected windows whenever an output handshake is presented.
module tb_pool2d_window_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pool2d_window_buffer_if #(.P0(8), .KH(2), .KW(2)) ifa ();
    pool2d_window_buffer_if #(.P0(8), .KH(3), .KW(3)) ifb ();
    pool2d_window_buffer_if #(.P0(8), .KH(2), .KW(2)) ifc ();

    pool2d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_WIDTH(2), .KERNEL_HEIGHT(2),
        .STRIDE(2)) u_a (.clk(clk), .rst(rst), .io(ifa.master));
    pool2d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
        .STRIDE(1)) u_b (.clk(clk), .rst(rst), .io(ifb.master));
    pool2d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_WIDTH(5), .DATA_IN_0_HEIGHT(5), .KERNEL_WIDTH(2), .KERNEL_HEIGHT(2),
        .STRIDE(2)) u_c (.clk(clk), .rst(rst), .io(ifc.master));

    int checks = 0;
    int errors = 0;
    int nwin [3];
    logic [71:0] expq [3][$];

    function automatic logic [71:0] pk4(input int a, input int b, input int c, input int d);
        return {40'd0, d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [71:0] pk9(input int a, input int b, input int c, input int d,
                                        input int e, input int f, input int g, input int h,
                                        input int k);
        return {k[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [71:0] get_win(input int sel);
        logic [71:0] r;
        r = '0;
        case (sel)
            0: for (int i = 0; i < 4; i++) r[i*8 +: 8] = ifa.data_out_0[i];
            1: for (int i = 0; i < 9; i++) r[i*8 +: 8] = ifb.data_out_0[i];
            default: for (int i = 0; i < 4; i++) r[i*8 +: 8] = ifc.data_out_0[i];
        endcase
        return r;
    endfunction

    function automatic logic out_vld(input int sel);
        case (sel)
            0: return ifa.data_out_0_valid;
            1: return ifb.data_out_0_valid;
            default: return ifc.data_out_0_valid;
        endcase
    endfunction

    function automatic logic out_rdy(input int sel);
        case (sel)
            0: return ifa.data_out_0_ready;
            1: return ifb.data_out_0_ready;
            default: return ifc.data_out_0_ready;
        endcase
    endfunction

    function automatic logic in_rdy(input int sel);
        case (sel)
            0: return ifa.data_in_0_ready;
            1: return ifb.data_in_0_ready;
            default: return ifc.data_in_0_ready;
        endcase
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic [7:0] v, input logic vld);
        case (sel)
            0: begin ifa.data_in_0 = v; ifa.data_in_0_valid = vld; end
            1: begin ifb.data_in_0 = v; ifb.data_in_0_valid = vld; end
            default: begin ifc.data_in_0 = v; ifc.data_in_0_valid = vld; end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int sel, input int v);
        logic acc;
        int   n;
        n = 0;
        acc = 1'b0;
        set_in(sel, v[7:0], 1'b1);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_rdy(sel);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst%0d value %0d not accepted in %0d cycles", sel, v, n);
        end
        set_in(sel, 8'd0, 1'b0);
    endtask

    task automatic push_t1(input int b);
        expq[0].push_back(pk4(b+0, b+1, b+4, b+5));
        expq[0].push_back(pk4(b+2, b+3, b+6, b+7));
        expq[0].push_back(pk4(b+8, b+9, b+12, b+13));
        expq[0].push_back(pk4(b+10, b+11, b+14, b+15));
    endtask

    task automatic push_t6(input int b);
        expq[2].push_back(pk4(b+0, b+1, b+5, b+6));
        expq[2].push_back(pk4(b+2, b+3, b+7, b+8));
        expq[2].push_back(pk4(b+10, b+11, b+15, b+16));
        expq[2].push_back(pk4(b+12, b+13, b+17, b+18));
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && (expq[0].size() + expq[1].size() + expq[2].size()) > 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [71:0] got;
        logic [71:0] exp;
        for (int s = 0; s < 3; s++) begin
            if (rst && out_vld(s) && out_rdy(s)) begin
                got = get_win(s);
                nwin[s]++;
                checks++;
                if (expq[s].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window inst%0d got %h expected none", s, got);
                end else begin
                    exp = expq[s].pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL window inst%0d #%0d got %h expected %h", s, nwin[s], got, exp);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) nwin[s] = 0;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 8'd0, 1'b0);
        ifa.data_out_0_ready = 1'b1;
        ifb.data_out_0_ready = 1'b1;
        ifc.data_out_0_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_valid%0d", s), {71'd0, out_vld(s)}, 72'd0);
            chk($sformatf("rst_data%0d", s), get_win(s), 72'd0);
            chk($sformatf("rst_in_ready%0d", s), {71'd0, in_rdy(s)}, 72'd1);
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // T1: 4x4, K2 S2, valid exactly one cycle after elements 5, 7, 13, 15
        push_t1(0);
        for (int i = 0; i < 16; i++) begin
            send(0, i);
            chk($sformatf("t1_latency_e%0d", i), {71'd0, ifa.data_out_0_valid},
                {71'd0, (i == 5 || i == 7 || i == 13 || i == 15)});
        end
        drain();

        // T2: 4x4, K3 S1
        expq[1].push_back(pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        expq[1].push_back(pk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        expq[1].push_back(pk9(4, 5, 6, 8, 9, 10, 12, 13, 14));
        expq[1].push_back(pk9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        for (int i = 0; i < 16; i++) send(1, i);
        drain();

        // T3: downstream stall of 5 cycles after the first window
        push_t1(0);
        fork
            begin
                for (int i = 0; i < 16; i++) send(0, i);
            end
            begin
                int t;
                t = 0;
                while (!ifa.data_out_0_valid && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("t3_first_valid_seen", {71'd0, ifa.data_out_0_valid}, 72'd1);
                ifa.data_out_0_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_stall_in_ready", {71'd0, ifa.data_in_0_ready}, 72'd0);
                    chk("t3_stall_valid", {71'd0, ifa.data_out_0_valid}, 72'd1);
                    chk("t3_stall_hold", get_win(0), pk4(0, 1, 4, 5));
                end
                @(posedge clk);
                #1 ifa.data_out_0_ready = 1'b1;
            end
        join
        drain();

        // T4: two frames back-to-back
        push_t1(0);
        push_t1(100);
        for (int i = 0; i < 16; i++) send(0, i);
        for (int i = 0; i < 16; i++) send(0, 100 + i);
        drain();

        // T5: reset mid-frame, then a clean frame
        for (int i = 0; i < 6; i++) send(0, i);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_rst_valid", {71'd0, ifa.data_out_0_valid}, 72'd0);
            chk("t5_rst_data", get_win(0), 72'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        push_t1(0);
        for (int i = 0; i < 16; i++) send(0, i);
        drain();

        // T6: 5x5, K2 S2; trailing row/col dropped, second frame checks wrap
        push_t6(0);
        push_t6(100);
        for (int i = 0; i < 25; i++) send(2, i);
        for (int i = 0; i < 25; i++) send(2, 100 + i);
        drain();

        for (int s = 0; s < 3; s++) begin
            chk($sformatf("queue_empty%0d", s), 72'(expq[s].size()), 72'd0);
        end
        chk("count_a", 72'(nwin[0]), 72'd20);
        chk("count_b", 72'(nwin[1]), 72'd4);
        chk("count_c", 72'(nwin[2]), 72'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
